ula_arbiter: RTL and testbench

- Shares the single registered MIPS ULA between two requesters, e.g. the main datapath (req0) and the branch/address unit (req1).
- Arbitrates with valid/ready handshakes, drives the ULA operand and opcode inputs, and holds them stable across the ULA's one-clock registered latency.
- Captures R/Z/O and returns them to the owning requester as a one-cycle response pulse.
- Sits between the requesters and the ULA instance; the ULA's clock input is tied to the same clock.

---
 rtl/ula_pkg.sv | 22 ++
 rtl/ula_rr_pick.sv | 22 ++
 rtl/ula_arbiter.sv | 112 +++++++++++
 tb/tb_ula_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA arbiter: opcode encodings, FSM states, default width.
// No logic here; imported by the arbiter, its grant picker and the bench.
package ula_pkg;

    localparam int ULA_WIDTH = 32;

    localparam logic [3:0] ULA_AND  = 4'b0000;
    localparam logic [3:0] ULA_OR   = 4'b0001;
    localparam logic [3:0] ULA_ADD  = 4'b0010;
    localparam logic [3:0] ULA_ADDU = 4'b0011;
    localparam logic [3:0] ULA_SUB  = 4'b0100;
    localparam logic [3:0] ULA_SUBU = 4'b0101;
    localparam logic [3:0] ULA_SLT  = 4'b0110;
    localparam logic [3:0] ULA_SLTU = 4'b0111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/ula_rr_pick.sv
// 2-way grant picker: round-robin against rr_last, or fixed priority to req0.
// Purely combinational, zero latency; no backpressure of its own.
module ula_rr_pick #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic       grant_vld,
    output logic       grant_idx
);

    always_comb begin
        grant_vld = |valid;
        grant_idx = 1'b0;
        if (valid == 2'b10) begin
            grant_idx = 1'b1;
        end else if (valid == 2'b11 && RR_ENABLE) begin
            grant_idx = ~rr_last;
        end
    end

endmodule

// File: rtl/ula_arbiter.sv
// Shares one registered ULA between two requesters; accept in cycle N, response pulse in N+3.
// Accepts only in IDLE (one op per 3 cycles); response path has no backpressure.
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int WIDTH     = ULA_WIDTH,
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req0_op,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_z,
    output logic             rsp_o,
    output logic             rsp_err,
    output logic             busy,
    output logic [3:0]       ula_op,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    input  logic [WIDTH-1:0] ula_r,
    input  logic             ula_z,
    input  logic             ula_o
);

    state_t           state, state_nxt;
    logic             owner;
    logic             err_q;
    logic             rr_last;
    logic             grant_vld;
    logic             grant_idx;
    logic             grant_take;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    ula_rr_pick #(
        .RR_ENABLE (RR_ENABLE)
    ) u_pick (
        .valid     (req_valid),
        .rr_last   (rr_last),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    assign sel_op     = grant_idx ? req1_op : req0_op;
    assign sel_a      = grant_idx ? req1_a  : req0_a;
    assign sel_b      = grant_idx ? req1_b  : req0_b;
    assign grant_take = (state == IDLE) && grant_vld;
    assign busy       = (state != IDLE);

    // Ready is combinational so the handshake completes in the grant cycle.
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = ISSUE;
                end
            end
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rsp_valid <= 2'b00;
            rsp_r     <= '0;
            rsp_z     <= 1'b0;
            rsp_o     <= 1'b0;
            rsp_err   <= 1'b0;
            ula_op    <= 4'b0000;
            ula_a     <= '0;
            ula_b     <= '0;
            owner     <= 1'b0;
            err_q     <= 1'b0;
            rr_last   <= 1'b1;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 2'b00;
            if (grant_take) begin
                ula_op  <= sel_op;
                ula_a   <= sel_a;
                ula_b   <= sel_b;
                owner   <= grant_idx;
                err_q   <= sel_op[3];
                rr_last <= grant_idx;
            end
            // Illegal opcodes mask R/O; Z still reports the held operands.
            if (state == CAPTURE) begin
                rsp_valid <= owner ? 2'b10 : 2'b01;
                rsp_r     <= err_q ? '0 : ula_r;
                rsp_z     <= ula_z;
                rsp_o     <= ula_o & ~err_q;
                rsp_err   <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: round-robin and fixed-priority instances against a cycle-timed transaction model.
module tb_ula_arbiter;
    import ula_pkg::*;

    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [1:0]   req_valid = 2'b00;
    logic [3:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;

    logic [1:0]   req_ready [2];
    logic [1:0]   rsp_valid [2];
    logic [W-1:0] rsp_r     [2];
    logic         rsp_z     [2];
    logic         rsp_o     [2];
    logic         rsp_err   [2];
    logic         busy      [2];
    logic [3:0]   ula_op    [2];
    logic [W-1:0] ula_a     [2];
    logic [W-1:0] ula_b     [2];
    logic [W-1:0] ula_r     [2];
    logic         ula_z     [2];
    logic         ula_o     [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit armed  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ULA behaviour: {O, R}; R forced to 0 on signed overflow.
    function automatic logic [W:0] ula_calc(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        logic         ov;
        ov = 1'b0;
        case (op)
            ULA_AND:  s = a & b;
            ULA_OR:   s = a | b;
            ULA_ADD:  begin s = a + b; ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]); end
            ULA_ADDU: s = a + b;
            ULA_SUB:  begin s = a - b; ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]); end
            ULA_SUBU: s = a - b;
            ULA_SLT:  s = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            ULA_SLTU: s = (a < b) ? W'(1) : W'(0);
            default:  begin s = 32'hDEADBEEF; ov = 1'b1; end
        endcase
        if (ov) s = '0;
        return {ov, s};
    endfunction

    always @(posedge clock) begin
        {ula_o[0], ula_r[0]} <= ula_calc(ula_op[0], ula_a[0], ula_b[0]);
        {ula_o[1], ula_r[1]} <= ula_calc(ula_op[1], ula_a[1], ula_b[1]);
    end
    assign ula_z[0] = (ula_a[0] == ula_b[0]);
    assign ula_z[1] = (ula_a[1] == ula_b[1]);

    ula_arbiter #(.WIDTH(W), .RR_ENABLE(1'b1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req0_op(req0_op), .req1_op(req1_op), .req0_a(req0_a), .req1_a(req1_a),
        .req0_b(req0_b), .req1_b(req1_b), .rsp_valid(rsp_valid[0]), .rsp_r(rsp_r[0]),
        .rsp_z(rsp_z[0]), .rsp_o(rsp_o[0]), .rsp_err(rsp_err[0]), .busy(busy[0]),
        .ula_op(ula_op[0]), .ula_a(ula_a[0]), .ula_b(ula_b[0]),
        .ula_r(ula_r[0]), .ula_z(ula_z[0]), .ula_o(ula_o[0])
    );

    ula_arbiter #(.WIDTH(W), .RR_ENABLE(1'b0)) dut_fp (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req0_op(req0_op), .req1_op(req1_op), .req0_a(req0_a), .req1_a(req1_a),
        .req0_b(req0_b), .req1_b(req1_b), .rsp_valid(rsp_valid[1]), .rsp_r(rsp_r[1]),
        .rsp_z(rsp_z[1]), .rsp_o(rsp_o[1]), .rsp_err(rsp_err[1]), .busy(busy[1]),
        .ula_op(ula_op[1]), .ula_a(ula_a[1]), .ula_b(ula_b[1]),
        .ula_r(ula_r[1]), .ula_z(ula_z[1]), .ula_o(ula_o[1])
    );

    // Transaction model: an accepted op occupies the unit for 3 cycles and
    // its response appears exactly 3 cycles after acceptance.
    int           m_free [2] = '{0, 0};
    logic         m_rr   [2];
    logic [3:0]   e_op   [2];
    logic [W-1:0] e_a    [2], e_b [2], e_r [2];
    logic [1:0]   e_rspv [2];
    logic         e_z    [2], e_o [2], e_err [2];
    bit           p_vld  [2] = '{0, 0};
    int           p_due  [2];
    logic         p_own  [2];
    logic [W-1:0] p_r    [2];
    logic         p_z    [2], p_o [2], p_err [2];
    int           gq0 [$], gc0 [$], gq1 [$];

    logic [1:0]   m_er;
    logic         m_g;
    logic [3:0]   m_op;
    logic [W-1:0] m_a, m_b;
    logic [W:0]   m_res;

    function automatic logic pick(input logic [1:0] v, input logic last, input bit rr);
        if (v == 2'b10) return 1'b1;
        if (v == 2'b11 && rr) return !last;
        return 1'b0;
    endfunction

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            m_er = 2'b00;
            m_g  = pick(req_valid, m_rr[k], k == 0);
            if (cyc >= m_free[k] && req_valid != 2'b00) m_er[m_g] = 1'b1;
            if (armed) begin
                check($sformatf("i%0d_req_ready", k), 64'(req_ready[k]), 64'(m_er));
                check($sformatf("i%0d_busy", k),      64'(busy[k]),      64'(cyc < m_free[k]));
                check($sformatf("i%0d_rsp_valid", k), 64'(rsp_valid[k]), 64'(e_rspv[k]));
                check($sformatf("i%0d_rsp_r", k),     64'(rsp_r[k]),     64'(e_r[k]));
                check($sformatf("i%0d_rsp_zoe", k),   64'({rsp_z[k], rsp_o[k], rsp_err[k]}),
                                                      64'({e_z[k], e_o[k], e_err[k]}));
                check($sformatf("i%0d_ula_op", k),    64'(ula_op[k]),    64'(e_op[k]));
                check($sformatf("i%0d_ula_a", k),     64'(ula_a[k]),     64'(e_a[k]));
                check($sformatf("i%0d_ula_b", k),     64'(ula_b[k]),     64'(e_b[k]));
            end
            if (reset) begin
                m_free[k] = cyc + 1; p_vld[k] = 0; m_rr[k] = 1'b1;
                e_op[k] = '0; e_a[k] = '0; e_b[k] = '0; e_rspv[k] = 2'b00;
                e_r[k] = '0; e_z[k] = 1'b0; e_o[k] = 1'b0; e_err[k] = 1'b0;
            end else begin
                e_rspv[k] = 2'b00;
                if (p_vld[k] && p_due[k] == cyc + 1) begin
                    e_rspv[k] = p_own[k] ? 2'b10 : 2'b01;
                    e_r[k] = p_r[k]; e_z[k] = p_z[k]; e_o[k] = p_o[k]; e_err[k] = p_err[k];
                    p_vld[k] = 0;
                end
                if (m_er != 2'b00) begin
                    m_op  = m_g ? req1_op : req0_op;
                    m_a   = m_g ? req1_a  : req0_a;
                    m_b   = m_g ? req1_b  : req0_b;
                    m_res = ula_calc(m_op, m_a, m_b);
                    e_op[k] = m_op; e_a[k] = m_a; e_b[k] = m_b;
                    m_rr[k] = m_g; m_free[k] = cyc + 3;
                    p_vld[k] = 1; p_due[k] = cyc + 3; p_own[k] = m_g;
                    p_err[k] = m_op[3];
                    p_r[k]   = m_op[3] ? '0 : m_res[W-1:0];
                    p_o[k]   = m_op[3] ? 1'b0 : m_res[W];
                    p_z[k]   = (m_a == m_b);
                    if (k == 0) begin gq0.push_back(int'(m_g)); gc0.push_back(cyc); end
                    else gq1.push_back(int'(m_g));
                end
            end
        end
        if (reset) armed = 1;
        cyc++;
    end

    task automatic issue(input int k, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int waits);
        bit got;
        got   = 0;
        waits = 0;
        if (k == 0) begin req0_op = op; req0_a = a; req0_b = b; end
        else        begin req1_op = op; req1_a = a; req1_b = b; end
        req_valid[k] = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (req_ready[0][k]) got = 1; else waits++;
        end
        if (!got) check("grant_timeout", 64'(0), 64'(1));
        @(posedge clock); #1;
        req_valid[k] = 1'b0;
    endtask

    task automatic run_one(input string name, input int k, input logic [3:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] xr, input logic xz, input logic xo, input logic xe);
        int w;
        issue(k, op, a, b, w);
        check({name, "_accept_wait"}, 64'(w), 64'(0));
        @(negedge clock);
        check({name, "_ula_op_c1"}, 64'(ula_op[0]), 64'(op));
        @(negedge clock);
        check({name, "_ula_ab_c2"}, 64'({ula_a[0], ula_b[0]}), 64'({a, b}));
        @(negedge clock);
        check({name, "_rsp_valid_c3"}, 64'(rsp_valid[0]), 64'(k == 1 ? 2'b10 : 2'b01));
        check({name, "_rsp_r"}, 64'(rsp_r[0]), 64'(xr));
        check({name, "_rsp_zoe"}, 64'({rsp_z[0], rsp_o[0], rsp_err[0]}), 64'({xz, xo, xe}));
        @(posedge clock); #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_busy",      64'(busy[0]),      64'(0));
        check("reset_rsp_valid", 64'(rsp_valid[0]), 64'(0));
        check("reset_ula_a",     64'(ula_a[0]),     64'(0));
        check("reset_ready",     64'(req_ready[0]), 64'(0));
        @(posedge clock); #1;

        run_one("add",   0, ULA_ADD,  32'd5,        32'd7,  32'd12, 1'b0, 1'b0, 1'b0);
        run_one("ovf",   1, ULA_ADD,  32'h7FFFFFFF, 32'd1,  32'd0,  1'b0, 1'b1, 1'b0);
        run_one("subu",  1, ULA_SUBU, 32'h10,       32'h10, 32'd0,  1'b1, 1'b0, 1'b0);
        run_one("illeg", 0, 4'b1010,  32'd3,        32'd3,  32'd0,  1'b1, 1'b0, 1'b1);
        run_one("slt",   0, ULA_SLT,  32'd3,        32'd5,  32'd1,  1'b0, 1'b0, 1'b0);

        // Reset while the op is in ISSUE: dropped, no response.
        issue(0, ULA_ADD, 32'd1, 32'd2, w);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_issue_busy",  64'(busy[0]),  64'(0));
        check("rst_issue_ula_a", 64'(ula_a[0]), 64'(0));
        @(negedge clock);
        check("rst_issue_no_rsp", 64'(rsp_valid[0]), 64'(0));
        @(posedge clock); #1;
        run_one("post_rst", 1, ULA_ADD, 32'd4, 32'd4, 32'd8, 1'b1, 1'b0, 1'b0);

        // Continuous contention from both requesters.
        gq0.delete(); gc0.delete(); gq1.delete();
        req0_op = ULA_AND; req0_a = 32'hFF00; req0_b = 32'h0FF0;
        req1_op = ULA_OR;  req1_a = 32'h1;    req1_b = 32'h2;
        req_valid = 2'b11;
        repeat (12) @(posedge clock);
        #1 req_valid = 2'b00;
        repeat (5) @(posedge clock);
        check("rr_grant_count", 64'(gq0.size()), 64'(4));
        for (int i = 0; i < gq0.size(); i++) begin
            check($sformatf("rr_grant_%0d", i), 64'(gq0[i]), 64'(i % 2));
            if (i > 0) check($sformatf("rr_spacing_%0d", i), 64'(gc0[i] - gc0[i-1]), 64'(3));
        end
        check("fp_grant_count", 64'(gq1.size()), 64'(4));
        for (int i = 0; i < gq1.size(); i++)
            check($sformatf("fp_grant_%0d", i), 64'(gq1[i]), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
